// File: rtl/scan_pkg.sv
// scan_pkg: shared definitions for the debugger scan path.
//   - scan_state_e : FSM state encoding used by debug_scan_chain
//   - MU0 register widths and the resulting default chain length
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } scan_state_e;

  localparam int ACC_W       = 16;
  localparam int PC_W        = 12;
  localparam int FLAGS_W     = 2;
  localparam int MU0_CHAIN_W = ACC_W + PC_W + FLAGS_W;

endpackage

// File: rtl/scan_shift_reg.sv
// scan_shift_reg: W-bit serial shift register for the scan chain.
// Ports:
//   clk_i       : scan clock
//   rst_ni      : synchronous active-low reset (clears the register)
//   clr_i       : discard contents (abandoned pass)
//   load_i      : capture-shift, q <= {ser_i, load_data_i}
//   shift_i     : plain shift, q <= {ser_i, q[W-1:1]}
//   ser_i       : serial input entering at the MSB end
//   load_data_i : capture bits 1..W-1 (bit 0 leaves the chain live)
//   q_o         : register contents, q_o[0] is the next bit out
module scan_shift_reg #(
  parameter int W = 30
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         ser_i,
  input  logic [W-2:0] load_data_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clr_i) begin
      shreg_d = '0;
    end else if (load_i) begin
      // Bit 0 is delivered live on the capture cycle, so only bits 1.. are kept.
      shreg_d = {ser_i, load_data_i};
    end else if (shift_i) begin
      shreg_d = {ser_i, shreg_q[W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/debug_scan_chain.sv
// debug_scan_chain: read/write scan path for the debugger.
// Snapshots cap_data, shifts it out LSB-first on scan_out while shifting
// scan_in into the MSB end, and after a completed pass optionally presents
// the received word on upd_data with a one-cycle upd_valid.
// Ports:
//   scan_clk   : only clock
//   scan_rst_n : synchronous active-low reset
//   cap_data   : live values to scan, bit 0 first
//   scan_en    : scan-mode enable
//   scan_in    : host serial data in
//   scan_out   : current chain bit
//   upd_data   : last complete shifted-in word
//   upd_valid  : one-cycle write-back strobe
//   scan_err   : one-cycle pulse, scan_en dropped mid-pass
//   busy       : state is not IDLE
//
// state  | meaning
// IDLE   | waiting for scan_en; scan_out shows cap_data[0] live
// SHIFT  | shifting; cnt = bits already shifted in the current pass
// UPDATE | upd_valid high for this single cycle
module debug_scan_chain
  import scan_pkg::*;
#(
  parameter int CHAIN_W  = MU0_CHAIN_W,
  parameter int WRITABLE = 1,
  parameter int CNT_W    = $clog2(CHAIN_W)
) (
  input  logic               scan_clk,
  input  logic               scan_rst_n,
  input  logic [CHAIN_W-1:0] cap_data,
  input  logic               scan_en,
  input  logic               scan_in,
  output logic               scan_out,
  output logic [CHAIN_W-1:0] upd_data,
  output logic               upd_valid,
  output logic               scan_err,
  output logic               busy
);

  scan_state_e        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pass_done_q;
  logic [CHAIN_W-1:0] upd_data_q;
  logic               upd_valid_q;
  logic               scan_err_q;
  logic [CHAIN_W-1:0] shreg;

  logic at_start;
  logic at_last;
  logic sr_load;
  logic sr_shift;
  logic sr_clr;

  // at_start: the cycle where bit 0 must come straight from cap_data.
  assign at_start = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
  assign at_last  = (cnt_q == CNT_W'(CHAIN_W - 1));

  assign sr_load  = scan_en && at_start;
  assign sr_shift = scan_en && (state_q == SHIFT) && (cnt_q != '0);
  assign sr_clr   = !scan_en && (state_q == SHIFT) && (cnt_q != '0);

  scan_shift_reg #(
    .W (CHAIN_W)
  ) u_shreg (
    .clk_i       (scan_clk),
    .rst_ni      (scan_rst_n),
    .clr_i       (sr_clr),
    .load_i      (sr_load),
    .shift_i     (sr_shift),
    .ser_i       (scan_in),
    .load_data_i (cap_data[CHAIN_W-1:1]),
    .q_o         (shreg)
  );

  always_ff @(posedge scan_clk) begin
    if (!scan_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pass_done_q <= 1'b0;
      upd_data_q  <= '0;
      upd_valid_q <= 1'b0;
      scan_err_q  <= 1'b0;
    end else begin
      upd_valid_q <= 1'b0;
      scan_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (scan_en) begin
            cnt_q       <= CNT_W'(1);
            pass_done_q <= 1'b0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (scan_en) begin
            if (cnt_q == '0) begin
              // Recapture; pass_done survives until the pass is under way.
              cnt_q <= CNT_W'(1);
            end else if (at_last) begin
              cnt_q       <= '0;
              pass_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(1)) begin
                pass_done_q <= 1'b0;
              end
            end
          end else if (cnt_q != '0) begin
            scan_err_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else if (pass_done_q && (WRITABLE != 0)) begin
            upd_data_q  <= shreg;
            upd_valid_q <= 1'b1;
            state_q     <= UPDATE;
          end else begin
            state_q <= IDLE;
          end
        end
        UPDATE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign scan_out  = at_start ? cap_data[0] : shreg[0];
  assign upd_data  = upd_data_q;
  assign upd_valid = upd_valid_q;
  assign scan_err  = scan_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_debug_scan_chain.sv
// Bench for debug_scan_chain: one writable and one read-only instance share
// all inputs. Expected scan_out bits are queued as each bit is driven and
// popped for comparison before the following clock edge.
module tb_debug_scan_chain;
  import scan_pkg::*;

  localparam int CW = MU0_CHAIN_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cap_data;
  logic          scan_en;
  logic          scan_in;

  logic          out_rw, valid_rw, err_rw, busy_rw;
  logic [CW-1:0] upd_rw;
  logic          out_ro, valid_ro, err_ro, busy_ro;
  logic [CW-1:0] upd_ro;

  int checks = 0;
  int errors = 0;
  int rw_upd_pulses = 0;
  int rw_err_pulses = 0;
  int ro_upd_pulses = 0;
  int ro_err_pulses = 0;

  logic sb[$];

  always #5 clk = ~clk;

  debug_scan_chain #(.CHAIN_W(CW), .WRITABLE(1)) u_rw (
    .scan_clk(clk), .scan_rst_n(rst_n), .cap_data(cap_data), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(out_rw), .upd_data(upd_rw), .upd_valid(valid_rw),
    .scan_err(err_rw), .busy(busy_rw)
  );

  debug_scan_chain #(.CHAIN_W(CW), .WRITABLE(0)) u_ro (
    .scan_clk(clk), .scan_rst_n(rst_n), .cap_data(cap_data), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(out_ro), .upd_data(upd_ro), .upd_valid(valid_ro),
    .scan_err(err_ro), .busy(busy_ro)
  );

  always @(negedge clk) begin
    if (valid_rw) rw_upd_pulses++;
    if (err_rw)   rw_err_pulses++;
    if (valid_ro) ro_upd_pulses++;
    if (err_ro)   ro_err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one serial bit, queue the bit expected on scan_out, compare it
  // before the edge, then advance one clock.
  task automatic step(input logic din, input logic exp_out, input string tag);
    logic e;
    scan_in = din;
    sb.push_back(exp_out);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, {31'd0, out_rw}, {31'd0, e});
    end
    tick();
  endtask

  initial begin
    logic [CW-1:0] cap_a, wr_word, snap, w1, w2, cap_f;
    logic [CW-1:0] upd_before;

    rst_n    = 1'b0;
    scan_en  = 1'b0;
    scan_in  = 1'b0;
    cap_a    = {2'b10, 12'h123, 16'hA5C3};
    cap_data = cap_a;
    tick();
    tick();

    // Reset state
    chk("rst_busy",     {31'd0, busy_rw},  32'd0);
    chk("rst_upd_data", {2'd0, upd_rw},    32'd0);
    chk("rst_valid",    {31'd0, valid_rw}, 32'd0);
    chk("rst_err",      {31'd0, err_rw},   32'd0);
    chk("rst_scan_out", {31'd0, out_rw},   {31'd0, cap_a[0]});
    rst_n = 1'b1;
    tick();

    // Read pass: chain comes out LSB-first
    scan_en = 1'b1;
    for (int k = 0; k < CW; k++) step(1'b0, cap_a[k], "read_bit");
    chk("read_busy_held", {31'd0, busy_rw}, 32'd1);

    // Write pass back-to-back: recapture while shifting in the write word
    wr_word = 30'h1555_AAAA;
    for (int k = 0; k < CW; k++) step(wr_word[k], cap_a[k], "write_pass_bit");
    scan_en = 1'b0;
    tick();
    chk("wr_valid",    {31'd0, valid_rw}, 32'd1);
    chk("wr_upd_data", {2'd0, upd_rw},    {2'd0, wr_word});
    chk("wr_busy_upd", {31'd0, busy_rw},  32'd1);
    tick();
    chk("wr_valid_one_cycle", {31'd0, valid_rw}, 32'd0);
    chk("wr_busy_low",        {31'd0, busy_rw},  32'd0);

    // Abort after 7 edges
    upd_before = upd_rw;
    scan_en = 1'b1;
    for (int k = 0; k < 7; k++) step(1'b1, cap_a[k], "abort_bit");
    scan_en = 1'b0;
    tick();
    chk("abort_err",      {31'd0, err_rw},   32'd1);
    chk("abort_valid",    {31'd0, valid_rw}, 32'd0);
    chk("abort_busy",     {31'd0, busy_rw},  32'd0);
    chk("abort_upd_keep", {2'd0, upd_rw},    {2'd0, upd_before});
    tick();
    chk("abort_err_one_cycle", {31'd0, err_rw}, 32'd0);

    // Snapshot consistency, then a second pass; only the last word applies
    snap = 30'h2B3C_4D5E;
    w1   = 30'h0F0F_0F0F;
    w2   = 30'h3333_5555;
    cap_data = snap;
    scan_en  = 1'b1;
    for (int k = 0; k < CW; k++) begin
      if (k == 10) cap_data = '1;
      step(w1[k], snap[k], "snap_bit");
    end
    for (int k = 0; k < CW; k++) step(w2[k], 1'b1, "second_pass_bit");
    scan_en = 1'b0;
    tick();
    chk("snap_valid",    {31'd0, valid_rw}, 32'd1);
    chk("snap_upd_last", {2'd0, upd_rw},    {2'd0, w2});
    tick();

    // Reset mid-shift at cnt = 15
    cap_f    = 30'h1234_5679;
    cap_data = cap_f;
    scan_en  = 1'b1;
    for (int k = 0; k < 15; k++) step(1'b1, cap_f[k], "pre_reset_bit");
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy",     {31'd0, busy_rw},  32'd0);
    chk("mid_rst_scan_out", {31'd0, out_rw},   {31'd0, cap_f[0]});
    chk("mid_rst_upd_data", {2'd0, upd_rw},    32'd0);
    chk("mid_rst_valid",    {31'd0, valid_rw}, 32'd0);
    chk("mid_rst_err",      {31'd0, err_rw},   32'd0);
    rst_n   = 1'b1;
    scan_en = 1'b0;
    tick();
    chk("post_rst_err",   {31'd0, err_rw},   32'd0);
    chk("post_rst_valid", {31'd0, valid_rw}, 32'd0);
    chk("post_rst_busy",  {31'd0, busy_rw},  32'd0);
    tick();

    // Totals across the whole run
    chk("rw_upd_pulses", rw_upd_pulses, 32'd2);
    chk("rw_err_pulses", rw_err_pulses, 32'd1);
    chk("ro_upd_pulses", ro_upd_pulses, 32'd0);
    chk("ro_err_pulses", ro_err_pulses, 32'd1);
    chk("ro_upd_data",   {2'd0, upd_ro}, 32'd0);
    chk("ro_busy_idle",  {31'd0, busy_ro}, 32'd0);
    chk("sb_drained",    sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
